// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the multi-channel soft clock divider.
// Ratios are carried internally at DIV_W_MAX bits; unused upper bits stay zero.
package clk_div_pkg;

    localparam int DIV_MIN   = 2;
    localparam int DIV_W_MAX = 16;

    typedef logic [DIV_W_MAX-1:0] div_t;

    typedef struct packed {
        div_t cnt;
        div_t cur_div;
        div_t pend_div;
        logic busy;
    } chan_state_t;

    function automatic div_t div_clamp(input div_t value);
        return (value < div_t'(DIV_MIN)) ? div_t'(DIV_MIN) : value;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: period counter, pending-ratio register, calib hold,
// and registered clkout / ce whose values always match the counter state.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 3
) (
    input  logic             hclkin,
    input  logic             resetn,
    input  logic             en,
    input  logic             calib,
    input  logic             wr,
    input  logic [DIV_W-1:0] wr_val,
    output logic             busy,
    output logic             clkout,
    output logic             ce
);

    chan_state_t state_q, state_d;
    logic        run_q, run_d;
    logic        clkout_q, clkout_d;
    logic        ce_q, ce_d;
    logic        wrap;

    assign wrap = (state_q.cnt == state_q.cur_div - div_t'(1));

    always_comb begin
        state_d = state_q;
        run_d   = en;

        if (!en) begin
            // Stopped channel: no period in flight, so a pending ratio can land now.
            state_d.cnt = '0;
            if (state_q.busy) begin
                state_d.cur_div = state_q.pend_div;
                state_d.busy    = 1'b0;
            end
        end else if (!run_q || (!calib && wrap)) begin
            state_d.cnt = '0;
            if (state_q.busy) begin
                state_d.cur_div = state_q.pend_div;
                state_d.busy    = 1'b0;
            end
        end else if (!calib) begin
            state_d.cnt = state_q.cnt + div_t'(1);
        end

        // A write on the apply edge stays pending for the following boundary.
        if (wr) begin
            state_d.pend_div = div_clamp(div_t'(wr_val));
            state_d.busy     = 1'b1;
        end

        clkout_d = en && (state_d.cnt < ((state_d.cur_div + div_t'(1)) >> 1));
        ce_d     = en && (state_d.cnt == state_d.cur_div - div_t'(1));
    end

    always_ff @(posedge hclkin or negedge resetn) begin
        if (!resetn) begin
            state_q.cnt      <= '0;
            state_q.cur_div  <= div_t'(DEFAULT_DIV);
            state_q.pend_div <= '0;
            state_q.busy     <= 1'b0;
            run_q            <= 1'b0;
            clkout_q         <= 1'b0;
            ce_q             <= 1'b0;
        end else begin
            state_q  <= state_d;
            run_q    <= run_d;
            clkout_q <= clkout_d;
            ce_q     <= ce_d;
        end
    end

    assign busy   = state_q.busy;
    assign clkout = clkout_q;
    assign ce     = ce_q;

endmodule

// File: rtl/clk_div_gen.sv
// NUM_CH independent run-time programmable clock dividers sharing one
// ratio write port; the top only decodes writes and acknowledges them.
module clk_div_gen
    import clk_div_pkg::*;
#(
    parameter  int NUM_CH      = 2,
    parameter  int DIV_W       = 8,
    parameter  int DEFAULT_DIV = 3,
    localparam int SEL_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              hclkin,
    input  logic              resetn,
    input  logic [NUM_CH-1:0] en,
    input  logic [NUM_CH-1:0] calib,
    input  logic              div_wr,
    input  logic [SEL_W-1:0]  div_sel,
    input  logic [DIV_W-1:0]  div_val,
    output logic              div_ack,
    output logic [NUM_CH-1:0] busy,
    output logic [NUM_CH-1:0] clkout,
    output logic [NUM_CH-1:0] ce
);

    logic              div_ack_q, div_ack_d;
    logic [NUM_CH-1:0] wr_hit;

    // Out-of-range selects match no channel but are still acknowledged.
    always_comb begin
        div_ack_d = div_wr;
    end

    always_ff @(posedge hclkin or negedge resetn) begin
        if (!resetn) begin
            div_ack_q <= 1'b0;
        end else begin
            div_ack_q <= div_ack_d;
        end
    end

    assign div_ack = div_ack_q;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
            assign wr_hit[gi] = div_wr && (div_sel == SEL_W'(gi));

            clk_div_chan #(
                .DIV_W       (DIV_W),
                .DEFAULT_DIV (DEFAULT_DIV)
            ) u_chan (
                .hclkin (hclkin),
                .resetn (resetn),
                .en     (en[gi]),
                .calib  (calib[gi]),
                .wr     (wr_hit[gi]),
                .wr_val (div_val),
                .busy   (busy[gi]),
                .clkout (clkout[gi]),
                .ce     (ce[gi])
            );
        end
    endgenerate

endmodule
